// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch-stage state encoding.
// The fetch unit and its bench import this package.
package pipeline_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // Canonical bubble: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// IF-stage producer: owns the fetch PC, runs one outstanding req/gnt/rvalid
// transaction at a time and presents {pc, instruction, valid} to IF/ID.
module instruction_fetch_unit
  import pipeline_pkg::*;
#(
  parameter int               XLEN     = pipeline_pkg::XLEN,
  parameter int               ILEN     = pipeline_pkg::ILEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(pipeline_pkg::RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic [ILEN-1:0] instruction,
  output logic            fetch_valid
);

  localparam logic [ILEN-1:0] NOP = ILEN'(NOP_INSTR);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] fetch_pc, fetch_pc_next;
  logic [ILEN-1:0] inst_buf, inst_buf_next;
  logic [XLEN-1:0] redirect_target;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      inst_buf <= NOP;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      inst_buf <= inst_buf_next;
    end
  end

  // Redirect is checked first in every state so it always wins over consume.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    inst_buf_next = inst_buf;

    case (state)
      IDLE: begin
        state_next = REQ;
        if (redirect) fetch_pc_next = redirect_target;
      end

      REQ: begin
        if (redirect) begin
          fetch_pc_next = redirect_target;
          // A granted request still owes us one response, which is now stale.
          state_next    = imem_gnt ? DRAIN : REQ;
        end else if (imem_gnt) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (redirect) begin
          fetch_pc_next = redirect_target;
          state_next    = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          inst_buf_next = imem_rdata;
          state_next    = HOLD;
        end
      end

      HOLD: begin
        if (redirect) begin
          fetch_pc_next = redirect_target;
          state_next    = REQ;
        end else if (pc_write) begin
          fetch_pc_next = fetch_pc + XLEN'(4);
          state_next    = REQ;
        end
      end

      DRAIN: begin
        if (redirect) fetch_pc_next = redirect_target;
        if (imem_rvalid) state_next = REQ;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = fetch_pc;
  assign pc_out      = fetch_pc;
  assign fetch_valid = (state == HOLD);
  assign instruction = fetch_valid ? inst_buf : NOP;

`ifndef SYNTHESIS
  // Memory may only answer while a granted request is outstanding.
  rvalid_only_when_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n)
      imem_rvalid |-> (state == WAIT || state == DRAIN)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a queue-based scoreboard:
// stimulus pushes expected grants/fetches, a negedge monitor pops and compares.
module tb_instruction_fetch_unit;
  import pipeline_pkg::*;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, redirect;
  logic [63:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid, fetch_valid;
  logic [63:0] imem_addr, pc_out;
  logic [31:0] imem_rdata, instruction;

  logic        b_rst_n;
  logic        b_req, b_gnt, b_rvalid, b_fetch_valid;
  logic [63:0] b_addr, b_pc_out;
  logic [31:0] b_rdata, b_instruction;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_addr_q[$];
  fetch_t      exp_fetch_q[$];

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instruction(instruction), .fetch_valid(fetch_valid)
  );

  instruction_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(b_rst_n), .pc_write(1'b1), .redirect(1'b0),
    .redirect_pc(64'h0), .imem_req(b_req), .imem_addr(b_addr),
    .imem_gnt(b_gnt), .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .pc_out(b_pc_out), .instruction(b_instruction), .fetch_valid(b_fetch_valid)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting in REQ: grant now, answer after wait_cycles idle WAIT cycles, end in HOLD.
  task automatic apply_stimulus(input logic [63:0] addr, input logic [31:0] data, input int wait_cycles);
    fetch_t f;
    imem_gnt = 1'b1;
    exp_addr_q.push_back(addr);
    tick();
    imem_gnt = 1'b0;
    repeat (wait_cycles) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    f.pc = addr;
    f.instr = data;
    exp_fetch_q.push_back(f);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_gnt) begin
        if (exp_addr_q.size() == 0) check_output("unexpected_grant_addr", imem_addr, 64'hX);
        else check_output("grant_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (fetch_valid) begin
        if (exp_fetch_q.size() == 0) begin
          check_output("unexpected_fetch_pc", pc_out, 64'hX);
        end else begin
          check_output("fetch_pc", pc_out, exp_fetch_q[0].pc);
          check_output("fetch_instr", {32'h0, instruction}, {32'h0, exp_fetch_q[0].instr});
          if (pc_write || redirect) void'(exp_fetch_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; b_rst_n = 1'b0;
    pc_write = 1'b1; redirect = 1'b0; redirect_pc = 64'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = 32'h0;
    repeat (2) tick();

    check_output("rst_req", {63'h0, imem_req}, 64'h0);
    check_output("rst_valid", {63'h0, fetch_valid}, 64'h0);
    check_output("rst_instr", {32'h0, instruction}, {32'h0, NOP_INSTR});
    check_output("rst_pc", pc_out, 64'h0);

    // Basic fetch: gnt in first REQ cycle, rvalid two cycles later.
    rst_n = 1'b1;
    tick();
    check_output("first_req", {63'h0, imem_req}, 64'h1);
    check_output("first_addr", imem_addr, 64'h0);
    apply_stimulus(64'h0, 32'h0050_0093, 1);
    tick();
    check_output("after_consume_valid", {63'h0, fetch_valid}, 64'h0);
    check_output("after_consume_instr", {32'h0, instruction}, {32'h0, NOP_INSTR});
    check_output("next_addr_4", imem_addr, 64'h4);

    // Stall in HOLD for five cycles.
    apply_stimulus(64'h4, 32'h00a0_0113, 0);
    pc_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("stall_req", {63'h0, imem_req}, 64'h0);
      check_output("stall_valid", {63'h0, fetch_valid}, 64'h1);
    end
    pc_write = 1'b1;
    tick();
    check_output("after_stall_addr", imem_addr, 64'h8);

    // Redirect during WAIT drains the stale response.
    imem_gnt = 1'b1;
    exp_addr_q.push_back(64'h8);
    tick();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h1002;
    tick();
    redirect = 1'b0;
    check_output("drain_req", {63'h0, imem_req}, 64'h0);
    check_output("drain_valid", {63'h0, fetch_valid}, 64'h0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check_output("post_drain_valid", {63'h0, fetch_valid}, 64'h0);
    check_output("post_drain_instr", {32'h0, instruction}, {32'h0, NOP_INSTR});
    check_output("post_drain_req", {63'h0, imem_req}, 64'h1);
    check_output("post_drain_addr", imem_addr, 64'h1000);

    // Redirect while REQ is not granted just moves the address.
    redirect = 1'b1; redirect_pc = 64'h200;
    tick();
    redirect = 1'b0;
    check_output("req_redirect_addr", imem_addr, 64'h200);
    check_output("req_redirect_req", {63'h0, imem_req}, 64'h1);
    apply_stimulus(64'h200, 32'h0010_0193, 0);

    // Redirect and consume on the same edge: redirect wins.
    pc_write = 1'b1; redirect = 1'b1; redirect_pc = 64'h3000;
    tick();
    redirect = 1'b0;
    check_output("redir_consume_valid", {63'h0, fetch_valid}, 64'h0);
    check_output("redir_consume_addr", imem_addr, 64'h3000);
    apply_stimulus(64'h3000, 32'h0000_0213, 0);
    tick();
    check_output("after_3000_addr", imem_addr, 64'h3004);

    // Reset while WAITing; the late response lands during reset.
    imem_gnt = 1'b1;
    exp_addr_q.push_back(64'h3004);
    tick();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_req", {63'h0, imem_req}, 64'h0);
    check_output("mid_rst_valid", {63'h0, fetch_valid}, 64'h0);
    check_output("mid_rst_instr", {32'h0, instruction}, {32'h0, NOP_INSTR});
    check_output("mid_rst_pc", pc_out, 64'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_rvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_output("post_rst_valid", {63'h0, fetch_valid}, 64'h0);
    check_output("post_rst_addr", imem_addr, 64'h0);
    apply_stimulus(64'h0, 32'h0050_0093, 0);
    tick();

    // PC wrap on the instance reset to the top word of the address space.
    b_rst_n = 1'b1;
    tick();
    check_output("wrap_first_addr", b_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    b_gnt = 1'b1;
    tick();
    b_gnt = 1'b0;
    b_rvalid = 1'b1; b_rdata = 32'h0070_0293;
    tick();
    b_rvalid = 1'b0;
    check_output("wrap_valid", {63'h0, b_fetch_valid}, 64'h1);
    check_output("wrap_pc", b_pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    check_output("wrap_instr", {32'h0, b_instruction}, 64'h0070_0293);
    tick();
    check_output("wrap_next_addr", b_addr, 64'h0);
    check_output("wrap_next_req", {63'h0, b_req}, 64'h1);

    check_output("addr_queue_empty", 64'(exp_addr_q.size()), 64'h0);
    check_output("fetch_queue_empty", 64'(exp_fetch_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
